// File: rtl/lz77_pkg.sv
// Shared field widths, token layout, packer state encoding and byte-packing helper
// for the LZ77 token packer.
package lz77_pkg;

  localparam int OFFSET_W = 4;
  localparam int LENGTH_W = 3;
  localparam int CHAR_W   = 8;
  localparam int TOKEN_W  = 1 + OFFSET_W + LENGTH_W + CHAR_W;

  typedef struct packed {
    logic                last;
    logic [OFFSET_W-1:0] offset;
    logic [LENGTH_W-1:0] length;
    logic [CHAR_W-1:0]   next_char;
  } token_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BYTE0 = 2'd1;
  localparam logic [1:0] BYTE1 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_BYTE0 = BYTE0,
    ST_BYTE1 = BYTE1,
    ST_DONE  = DONE
  } state_e;

  function automatic logic [7:0] pack_byte0(input token_t t);
    return {t.last, t.offset, t.length};
  endfunction

endpackage

// File: rtl/lz77_token_fifo.sv
// Small token FIFO with occupancy count and a look-ahead view of the entry behind the head,
// so the packer can register the next byte0 on the same cycle it pops.
module lz77_token_fifo
  import lz77_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = TOKEN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head_next,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_inc_s;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against current occupancy; a full FIFO refuses a push even during a pop.
  always_comb begin
    push_ok_s    = push && (count_r != CNT_FULL);
    pop_ok_s     = pop && (count_r != {CNT_W{1'b0}});
    rd_ptr_inc_s = rd_ptr_r + PTR_W'(1'b1);
  end

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign head_next = mem_r[rd_ptr_inc_s];
  assign count     = count_r;

endmodule

// File: rtl/lz77_token_packer.sv
// Packs LZ77 tokens into a two-byte stream: {last, offset, length} then the literal character.
// Field widths come from lz77_pkg; the parameters below must match those package values.
module lz77_token_packer #(
  parameter int OFFSET_W   = 4,
  parameter int LENGTH_W   = 3,
  parameter int CHAR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                tok_valid,
  input  logic [OFFSET_W-1:0] tok_offset,
  input  logic [LENGTH_W-1:0] tok_length,
  input  logic [CHAR_W-1:0]   tok_char,
  input  logic                tok_last,
  output logic                tok_ready,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                done,
  output logic                tok_drop,
  output logic [15:0]         tok_count
);
  import lz77_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [7:0]       out_data_r;
  logic [7:0]       data_nxt_s;
  logic             out_valid_r;
  logic             done_r;
  logic             tok_drop_r;
  logic [15:0]      tok_count_r;
  token_t           in_tok_s;
  token_t           head_tok_s;
  token_t           next_tok_s;
  logic [TOKEN_W-1:0] head_s;
  logic [TOKEN_W-1:0] head_next_s;
  logic             full_s;
  logic             empty_s;
  logic [CNT_W-1:0] count_s;
  logic             tok_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             start_ok_s;

  // Handshake decode; tok_ready depends only on registered state, never on out_ready.
  always_comb begin
    in_tok_s    = '{last: tok_last, offset: tok_offset, length: tok_length, next_char: tok_char};
    head_tok_s  = token_t'(head_s);
    next_tok_s  = token_t'(head_next_s);
    tok_ready_s = !full_s && (state_r != ST_DONE);
    push_s      = tok_valid && tok_ready_s;
    pop_s       = (state_r == ST_BYTE1) && out_ready;
    start_ok_s  = start && (state_r == ST_DONE);
  end

  lz77_token_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TOKEN_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start_ok_s),
    .push      (push_s),
    .pop       (pop_s),
    .din       (in_tok_s),
    .full      (full_s),
    .empty     (empty_s),
    .head      (head_s),
    .head_next (head_next_s),
    .count     (count_s)
  );

  // Next state and next output byte; out_data only changes on a state transition so it holds under backpressure.
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = out_data_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_nxt_s = ST_BYTE0;
          data_nxt_s  = pack_byte0(head_tok_s);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BYTE0: begin
        if (out_ready) begin
          state_nxt_s = ST_BYTE1;
          data_nxt_s  = head_tok_s.next_char;
        end else begin
          state_nxt_s = ST_BYTE0;
        end
      end
      ST_BYTE1: begin
        if (!out_ready) begin
          state_nxt_s = ST_BYTE1;
        end else if (head_tok_s.last) begin
          state_nxt_s = ST_DONE;
          data_nxt_s  = 8'h00;
        end else if (count_s > CNT_ONE) begin
          state_nxt_s = ST_BYTE0;
          data_nxt_s  = pack_byte0(next_tok_s);
        end else begin
          state_nxt_s = ST_IDLE;
          data_nxt_s  = 8'h00;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        data_nxt_s  = 8'h00;
      end
    endcase
  end

  // FSM, registered outputs and status counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      tok_drop_r  <= 1'b0;
      tok_count_r <= 16'h0000;
    end else begin
      state_r     <= state_nxt_s;
      out_data_r  <= data_nxt_s;
      out_valid_r <= (state_nxt_s == ST_BYTE0) || (state_nxt_s == ST_BYTE1);
      done_r      <= (state_nxt_s == ST_DONE);
      if (start_ok_s) begin
        tok_drop_r <= 1'b0;
      end else if (tok_valid && !tok_ready_s) begin
        tok_drop_r <= 1'b1;
      end else begin
        tok_drop_r <= tok_drop_r;
      end
      if (start_ok_s) begin
        tok_count_r <= 16'h0000;
      end else if (pop_s) begin
        tok_count_r <= tok_count_r + 16'h0001;
      end else begin
        tok_count_r <= tok_count_r;
      end
    end
  end

  assign tok_ready = tok_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign done      = done_r;
  assign tok_drop  = tok_drop_r;
  assign tok_count = tok_count_r;

endmodule
